// File: rtl/fifo_vector_packer_if.sv
// Packer-side bundle: FIFO read port, start control and packed vector output.
// master = packer, slave = FIFO/controller/downstream environment.
interface fifo_vector_packer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_PIXELS  = 64,
    parameter int COUNT_WIDTH = 7
);
    logic                             start;
    logic                             fifo_empty;
    logic                             fifo_rd_en;
    logic [DATA_WIDTH-1:0]            fifo_rd_data;
    logic                             fifo_rd_valid;
    logic [DATA_WIDTH*NUM_PIXELS-1:0] vector_out;
    logic                             vector_valid;
    logic                             vector_ready;
    logic                             busy;
    logic [COUNT_WIDTH:0]             pixel_count;

    modport master (
        input  start,
        input  fifo_empty,
        input  fifo_rd_data,
        input  fifo_rd_valid,
        input  vector_ready,
        output fifo_rd_en,
        output vector_out,
        output vector_valid,
        output busy,
        output pixel_count
    );

    modport slave (
        output start,
        output fifo_empty,
        output fifo_rd_data,
        output fifo_rd_valid,
        output vector_ready,
        input  fifo_rd_en,
        input  vector_out,
        input  vector_valid,
        input  busy,
        input  pixel_count
    );
endinterface

// File: rtl/fifo_vector_packer.sv
// Drains NUM_PIXELS words from the pixel FIFO into one flat vector and
// holds it with valid/ready until the next layer accepts it.
module fifo_vector_packer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_PIXELS  = 64,
    parameter int COUNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_vector_packer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LP_N    = COUNT_WIDTH'(NUM_PIXELS);
    localparam logic [COUNT_WIDTH-1:0] LP_LAST = COUNT_WIDTH'(NUM_PIXELS - 1);

    state_t                           r_state;
    logic [COUNT_WIDTH-1:0]           r_issue_cnt;
    logic [COUNT_WIDTH-1:0]           r_recv_cnt;
    logic                             r_valid;
    logic                             r_busy;
    logic [DATA_WIDTH*NUM_PIXELS-1:0] r_vec;

    logic w_rd_en;
    logic w_wr;
    logic w_last;

    // Reads stop once a full vector is issued; surplus stays in the FIFO.
    assign w_rd_en = (r_state == S_COLLECT) && !bus.fifo_empty
                     && (r_issue_cnt < LP_N);
    assign w_wr    = (r_state == S_COLLECT) && bus.fifo_rd_valid;
    assign w_last  = w_wr && (r_recv_cnt == LP_LAST);

    assign bus.fifo_rd_en   = w_rd_en;
    assign bus.vector_out   = r_vec;
    assign bus.vector_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.pixel_count  = {1'b0, r_recv_cnt};

    // Control FSM: counters, registered valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_COLLECT;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (w_rd_en)
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    if (w_wr)
                        r_recv_cnt <= r_recv_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.vector_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Slot write: each returned word lands at slot recv_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (r_recv_cnt == COUNT_WIDTH'(i))
                    r_vec[i*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_rd_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_vector_packer.sv
// Directed bench for fifo_vector_packer with a behavioural FIFO
// (registered empty, read data one cycle after accepted read).
module tb_fifo_vector_packer;
    localparam int DW = 16;
    localparam int NP = 64;
    localparam int CW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_vector_packer_if #(
        .DATA_WIDTH(DW), .NUM_PIXELS(NP), .COUNT_WIDTH(CW)
    ) bus ();

    fifo_vector_packer #(
        .DATA_WIDTH(DW), .NUM_PIXELS(NP), .COUNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] q[$];
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          r_empty;
    logic          f_valid;
    logic [DW-1:0] f_data;
    logic          inj_valid = 1'b0;
    logic [DW-1:0] inj_data = '0;
    int            rd_cnt;

    // FIFO model, reset on the same rst_n as the packer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            r_empty <= 1'b1;
            f_valid <= 1'b0;
            f_data  <= '0;
            rd_cnt  <= 0;
        end else begin
            if (bus.fifo_rd_en) begin
                f_data  <= q.pop_front();
                f_valid <= 1'b1;
                rd_cnt  <= rd_cnt + 1;
            end else begin
                f_valid <= 1'b0;
            end
            if (push_en)
                q.push_back(push_data);
            r_empty <= (q.size() == 0);
        end
    end

    assign bus.fifo_empty    = r_empty;
    assign bus.fifo_rd_valid = f_valid | inj_valid;
    assign bus.fifo_rd_data  = inj_valid ? inj_data : f_data;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = DW'(base + i);
            @(negedge clk);
        end
        push_en = 1'b0;
    endtask

    // Pulse start in cycle 0; lat = first cycle with vector_valid high.
    task automatic start_wait(output int lat);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.vector_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_slots(input string tag, input int base);
        for (int i = 0; i < NP; i++)
            check($sformatf("%s slot%0d", tag, i),
                  64'(bus.vector_out[i*DW +: DW]), 64'(DW'(base + i)));
    endtask

    task automatic handshake(input string tag);
        bus.vector_ready = 1'b1;
        @(negedge clk);
        bus.vector_ready = 1'b0;
        check({tag, " valid drop"}, 64'(bus.vector_valid), 64'd0);
        check({tag, " busy drop"}, 64'(bus.busy), 64'd0);
    endtask

    int lat;
    int rd_base;
    int trk_err;
    int pc_err;
    int prev_pc;
    int wait_n;
    logic [DW*NP-1:0] v0;

    initial begin
        bus.start        = 1'b0;
        bus.vector_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst valid", 64'(bus.vector_valid), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst pcount", 64'(bus.pixel_count), 64'd0);
        check("rst vec_nz", 64'(bus.vector_out != '0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // best case: 64 preloaded words
        push_words(0, NP);
        rd_base = rd_cnt;
        start_wait(lat);
        check("t1 latency", 64'(lat), 64'd66);
        check("t1 rd_cnt", 64'(rd_cnt - rd_base), 64'd64);
        check("t1 pcount", 64'(bus.pixel_count), 64'd64);
        check_slots("t1", 0);
        repeat (5) @(negedge clk);
        check("t1 hold valid", 64'(bus.vector_valid), 64'd1);
        check("t1 hold busy", 64'(bus.busy), 64'd1);
        handshake("t1");
        check("t1 rd_cnt end", 64'(rd_cnt - rd_base), 64'd64);

        // surplus words stay in the FIFO
        push_words(0, 70);
        rd_base = rd_cnt;
        start_wait(lat);
        check("t2 latency", 64'(lat), 64'd66);
        repeat (3) @(negedge clk);
        check("t2 rd_cnt", 64'(rd_cnt - rd_base), 64'd64);
        check("t2 level", 64'(q.size()), 64'd6);
        check_slots("t2a", 0);
        handshake("t2");
        push_words(70, 58);
        start_wait(lat);
        check("t2b latency", 64'(lat), 64'd66);
        check_slots("t2b", 64);
        handshake("t2b");

        // slow writer: one word every 3 cycles, stray start mid-collect
        trk_err = 0;
        pc_err  = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        fork
            begin
                for (int i = 0; i < NP; i++) begin
                    push_en   = 1'b1;
                    push_data = DW'(16'h1000 + i);
                    if (i == 10)
                        bus.start = 1'b1;
                    @(negedge clk);
                    push_en   = 1'b0;
                    bus.start = 1'b0;
                    repeat (2) @(negedge clk);
                end
            end
            begin
                lat     = 1;
                prev_pc = 0;
                while (!bus.vector_valid && lat < 400) begin
                    if (bus.fifo_rd_en !== !bus.fifo_empty)
                        trk_err++;
                    if (int'(bus.pixel_count) != prev_pc &&
                        int'(bus.pixel_count) != prev_pc + 1)
                        pc_err++;
                    prev_pc = int'(bus.pixel_count);
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("t3 done", 64'(bus.vector_valid), 64'd1);
        check("t3 rd_en track", 64'(trk_err), 64'd0);
        check("t3 pc step", 64'(pc_err), 64'd0);
        check("t3 pcount", 64'(bus.pixel_count), 64'd64);
        check_slots("t3", 16'h1000);

        // start in DONE ignored; start with ready honours ready
        v0 = bus.vector_out;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4 done valid", 64'(bus.vector_valid), 64'd1);
        check("t4 done frozen", 64'(bus.vector_out == v0), 64'd1);
        bus.start        = 1'b1;
        bus.vector_ready = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.vector_ready = 1'b0;
        check("t4 sr valid", 64'(bus.vector_valid), 64'd0);
        check("t4 sr busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("t4 idle busy", 64'(bus.busy), 64'd0);
        inj_valid = 1'b1;
        inj_data  = 16'hDEAD;
        @(negedge clk);
        inj_valid = 1'b0;
        @(negedge clk);
        check("t4 stray vec", 64'(bus.vector_out == v0), 64'd1);
        check("t4 stray busy", 64'(bus.busy), 64'd0);
        check("t4 stray pc", 64'(bus.pixel_count), 64'd64);

        // async reset mid-vector at pixel_count 30
        push_words(16'h0100, NP);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_n = 0;
        while (bus.pixel_count != 8'd30 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        check("t5 reach30", 64'(bus.pixel_count), 64'd30);
        #2 rst_n = 1'b0;
        #1;
        check("t5 rst valid", 64'(bus.vector_valid), 64'd0);
        check("t5 rst busy", 64'(bus.busy), 64'd0);
        check("t5 rst pc", 64'(bus.pixel_count), 64'd0);
        check("t5 rst rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("t5 rst vec_nz", 64'(bus.vector_out != '0), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t5 fifo clear", 64'(q.size()), 64'd0);
        push_words(16'h2000, NP);
        start_wait(lat);
        check("t5 latency", 64'(lat), 64'd66);
        check_slots("t5", 16'h2000);
        handshake("t5");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
